// File: rtl/bitcoin_nonce_search_if.sv
`default_nettype none
// ============================================================================
// bitcoin_nonce_search_if: single-port SRAM bus between the nonce searcher and its memory.  Rev 1.0
// ============================================================================
interface bitcoin_nonce_search_if;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport master (
    output mem_clk,
    output mem_we,
    output mem_addr,
    output mem_write_data,
    input  mem_read_data
  );

  modport slave (
    input  mem_clk,
    input  mem_we,
    input  mem_addr,
    input  mem_write_data,
    output mem_read_data
  );
endinterface
`default_nettype wire

// File: rtl/bitcoin_nonce_search.sv
`default_nettype none
// ============================================================================
// bitcoin_nonce_search: double SHA-256 nonce sweep on one round engine, midstate reused.  Rev 1.0
// ============================================================================
module bitcoin_nonce_search #(
  parameter int NUM_NONCES = 16,
  parameter int MODE       = 0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [15:0]                   message_addr,
  input  logic [15:0]                   output_addr,
  input  logic [31:0]                   nonce_base,
  input  logic [31:0]                   target,
  output logic                          done,
  output logic                          found,
  output logic [31:0]                   found_nonce,
  bitcoin_nonce_search_if.master        mem
);

  localparam logic [15:0] LAST_IDX = 16'(NUM_NONCES - 1);

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_BLK1   = 4'd2,
    S_MID    = 4'd3,
    S_BLK2   = 4'd4,
    S_ADD2   = 4'd5,
    S_BLK3   = 4'd6,
    S_ADD3   = 4'd7,
    S_WRITE  = 4'd8,
    S_WRITE2 = 4'd9,
    S_DONE   = 4'd10
  } state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] msg_addr_q, msg_addr_d;
  logic [15:0] out_addr_q, out_addr_d;
  logic [31:0] nonce_base_q, nonce_base_d;
  logic [31:0] target_q, target_d;
  logic [31:0] hdr_q [3];
  logic [31:0] hdr_d [3];
  logic [31:0] w_q [16];
  logic [31:0] w_d [16];
  logic [31:0] v_q [8];
  logic [31:0] v_d [8];
  logic [31:0] mid_q [8];
  logic [31:0] mid_d [8];
  logic [31:0] h0p_q, h0p_d;
  logic        done_q, done_d;
  logic        found_q, found_d;
  logic [31:0] found_nonce_q, found_nonce_d;

  logic        w_mem_we;
  logic [15:0] w_mem_addr;
  logic [31:0] w_mem_wdata;
  logic        w_ld_blk2;
  logic [31:0] w_ld_nonce;
  logic [5:0]  w_prev;
  logic [31:0] w_nonce;
  logic        w_hit;
  logic        w_last;
  logic [31:0] w_t1, w_t2, w_wnext;

  // One compression round and the sliding message-schedule window update.
  assign w_t1    = v_q[7] + bsig1(v_q[4]) + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]))
                 + K[cnt_q] + w_q[0];
  assign w_t2    = bsig0(v_q[0]) + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
  assign w_wnext = w_q[0] + ssig0(w_q[1]) + w_q[9] + ssig1(w_q[14]);

  assign w_prev  = cnt_q - 6'd1;
  assign w_nonce = nonce_base_q + {16'd0, idx_q};
  assign w_hit   = (h0p_q < target_q);
  assign w_last  = (idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    msg_addr_d    = msg_addr_q;
    out_addr_d    = out_addr_q;
    nonce_base_d  = nonce_base_q;
    target_d      = target_q;
    hdr_d         = hdr_q;
    w_d           = w_q;
    v_d           = v_q;
    mid_d         = mid_q;
    h0p_d         = h0p_q;
    done_d        = done_q;
    found_d       = found_q;
    found_nonce_d = found_nonce_q;
    w_mem_we      = 1'b0;
    w_mem_addr    = 16'd0;
    w_mem_wdata   = 32'd0;
    w_ld_blk2     = 1'b0;
    w_ld_nonce    = 32'd0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          msg_addr_d    = message_addr;
          out_addr_d    = output_addr;
          nonce_base_d  = nonce_base;
          target_d      = target;
          done_d        = 1'b0;
          found_d       = 1'b0;
          found_nonce_d = 32'd0;
          cnt_d         = 6'd0;
          state_d       = S_FETCH;
        end
      end

      S_FETCH: begin
        if (cnt_q < 6'd19) begin
          w_mem_addr = msg_addr_q + {10'd0, cnt_q};
        end
        // Read data lags the address by one cycle: word cnt-1 arrives now.
        if (cnt_q != 6'd0) begin
          if (w_prev < 6'd16) begin
            w_d[w_prev[3:0]] = mem.mem_read_data;
          end else begin
            hdr_d[w_prev[1:0]] = mem.mem_read_data;
          end
        end
        if (cnt_q == 6'd19) begin
          cnt_d   = 6'd0;
          state_d = S_BLK1;
          for (int j = 0; j < 8; j++) v_d[j] = IV[j];
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end

      S_BLK1, S_BLK2, S_BLK3: begin
        v_d[0] = w_t1 + w_t2;
        v_d[1] = v_q[0];
        v_d[2] = v_q[1];
        v_d[3] = v_q[2];
        v_d[4] = v_q[3] + w_t1;
        v_d[5] = v_q[4];
        v_d[6] = v_q[5];
        v_d[7] = v_q[6];
        for (int j = 0; j < 15; j++) w_d[j] = w_q[j + 1];
        w_d[15] = w_wnext;
        cnt_d   = cnt_q + 6'd1;
        if (cnt_q == 6'd63) begin
          if (state_q == S_BLK1)      state_d = S_MID;
          else if (state_q == S_BLK2) state_d = S_ADD2;
          else                        state_d = S_ADD3;
        end
      end

      S_MID: begin
        for (int j = 0; j < 8; j++) mid_d[j] = IV[j] + v_q[j];
        idx_d      = 16'd0;
        w_ld_blk2  = 1'b1;
        w_ld_nonce = nonce_base_q;
        state_d    = S_BLK2;
      end

      S_ADD2: begin
        for (int j = 0; j < 8; j++) begin
          w_d[j] = mid_q[j] + v_q[j];
          v_d[j] = IV[j];
        end
        w_d[8] = 32'h80000000;
        for (int j = 9; j < 15; j++) w_d[j] = 32'd0;
        w_d[15] = 32'd256;
        state_d = S_BLK3;
      end

      S_ADD3: begin
        h0p_d   = IV[0] + v_q[0];
        state_d = S_WRITE;
      end

      S_WRITE: begin
        if (MODE == 0) begin
          w_mem_we    = 1'b1;
          w_mem_addr  = out_addr_q + idx_q;
          w_mem_wdata = h0p_q;
        end else if (w_hit) begin
          w_mem_we      = 1'b1;
          w_mem_addr    = out_addr_q;
          w_mem_wdata   = w_nonce;
          found_d       = 1'b1;
          found_nonce_d = w_nonce;
        end

        if ((MODE != 0) && w_hit) begin
          state_d = S_WRITE2;
        end else if (w_last) begin
          if (MODE == 0) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_WRITE2;
          end
        end else begin
          idx_d      = idx_q + 16'd1;
          w_ld_blk2  = 1'b1;
          w_ld_nonce = w_nonce + 32'd1;
          state_d    = S_BLK2;
        end
      end

      S_WRITE2: begin
        w_mem_we = 1'b1;
        if (found_q) begin
          w_mem_addr  = out_addr_q + 16'd1;
          w_mem_wdata = h0p_q;
        end else begin
          w_mem_addr  = out_addr_q;
          w_mem_wdata = 32'hFFFFFFFF;
        end
        done_d  = 1'b1;
        state_d = S_DONE;
      end

      default: state_d = S_IDLE;
    endcase

    // Second block always starts from the midstate with a fresh nonce in W3.
    if (w_ld_blk2) begin
      for (int j = 0; j < 8; j++) v_d[j] = mid_d[j];
      w_d[0] = hdr_q[0];
      w_d[1] = hdr_q[1];
      w_d[2] = hdr_q[2];
      w_d[3] = w_ld_nonce;
      w_d[4] = 32'h80000000;
      for (int j = 5; j < 15; j++) w_d[j] = 32'd0;
      w_d[15] = 32'd640;
      cnt_d   = 6'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q         <= 6'd0;
      idx_q         <= 16'd0;
      msg_addr_q    <= 16'd0;
      out_addr_q    <= 16'd0;
      nonce_base_q  <= 32'd0;
      target_q      <= 32'd0;
      h0p_q         <= 32'd0;
      done_q        <= 1'b0;
      found_q       <= 1'b0;
      found_nonce_q <= 32'd0;
      for (int j = 0; j < 3; j++)  hdr_q[j] <= 32'd0;
      for (int j = 0; j < 16; j++) w_q[j]   <= 32'd0;
      for (int j = 0; j < 8; j++) begin
        v_q[j]   <= 32'd0;
        mid_q[j] <= 32'd0;
      end
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      msg_addr_q    <= msg_addr_d;
      out_addr_q    <= out_addr_d;
      nonce_base_q  <= nonce_base_d;
      target_q      <= target_d;
      h0p_q         <= h0p_d;
      done_q        <= done_d;
      found_q       <= found_d;
      found_nonce_q <= found_nonce_d;
      hdr_q         <= hdr_d;
      w_q           <= w_d;
      v_q           <= v_d;
      mid_q         <= mid_d;
    end
  end

  assign done               = done_q;
  assign found              = found_q;
  assign found_nonce        = found_nonce_q;
  assign mem.mem_clk        = clk;
  assign mem.mem_we         = w_mem_we;
  assign mem.mem_addr       = w_mem_addr;
  assign mem.mem_write_data = w_mem_wdata;

endmodule
`default_nettype wire

// File: doc/bitcoin_nonce_search.md
# bitcoin_nonce_search

Parametrised successor to `bitcoin_hash`. It reads a 19-word block header from the shared single-port SRAM and sweeps `NUM_NONCES` nonces starting at a runtime base. For each nonce it computes the double SHA-256 on one round engine, 1 round/cycle, reusing the block-1 midstate. In `MODE=0` it writes H0 for every nonce. In `MODE=1` it stops at the first nonce whose H0 is below a target and reports that nonce.

## Interface
- `NUM_NONCES`, 16: nonces swept per run, 1..65535.
- `MODE`, 0: 0 = write H0 per nonce; 1 = target search with early stop.
- `clk` in 1: single clock; all state on rising edge.
- `reset_n` in 1: reset is asynchronous and active-low.
- `start` in 1: level; accepted only in IDLE or DONE.
- `message_addr` in 16: base address of the 19 header words; sampled at start.
- `output_addr` in 16: result base address; sampled at start.
- `nonce_base` in 32: first nonce; sampled at start.
- `target` in 32: H0 threshold for `MODE=1`; sampled at start.
- `done` out 1: high in DONE until the next start is accepted.
- `found` out 1: `MODE=1` hit flag; valid while `done`.
- `found_nonce` out 32: winning nonce; valid while `done` and `found`.
- `mem_clk` out 1: equals `clk`.
- `mem_we` out 1: write strobe.
- `mem_addr` out 16: SRAM address.
- `mem_write_data` out 32: write data.
- `mem_read_data` in 32: read data.

## Operation
- **Reset values:** state IDLE; `done`, `found`, `found_nonce`, `mem_we`, `mem_addr`, `mem_write_data` are all 0.
- **SRAM read latency:** the SRAM samples `mem_addr` at edge k and updates `mem_read_data` after edge k; the block captures it at edge k+1.
- **IDLE/DONE:** when `start`=1, latch the four inputs, clear `done`/`found`/`found_nonce`, go to FETCH.
  - `start` in any other state is ignored.
  - Holding `start` high for several cycles never causes a second run.
- **FETCH, 20 cycles:** issue reads of `message_addr`+0..18, plus one drain cycle.
  - Store words 0..15 as block-1 W.
  - Store words 16..18 as block-2 W0..W2.
- **BLK1, 64 cycles:** rounds t=0..63 from the standard SHA-256 IV.
  - Message schedule is a 16-entry sliding window: W[t] = W[t-16] + s0(W[t-15]) + W[t-7] + s1(W[t-2]), all mod 2^32.
- **MID, 1 cycle:** midstate = IV + {a..h}; nonce index i = 0.
- **BLK2, 64 cycles:** start from the midstate.
  - W0..2 = header words 16..18, W3 = `nonce_base`+i (mod 2^32).
  - W4 = 0x80000000, W5..14 = 0, W15 = 640.
- **ADD2, 1 cycle:** H = midstate + {a..h}.
- **BLK3, 64 cycles:** start from the IV.
  - W0..7 = H, W8 = 0x80000000, W9..14 = 0, W15 = 256.
- **ADD3, 1 cycle:** H0' = IV0 + a.
- **WRITE, 1 cycle:**
  - `MODE=0`: write H0' to `output_addr`+i.
  - `MODE=1`, H0' < `target` (unsigned, strict): write the nonce to `output_addr`; set `found`=1, `found_nonce`=nonce; go to WRITE2.
  - `MODE=1`, no hit: `mem_we`=0 (idle cycle).
  - Afterwards: i==NUM_NONCES-1 goes to DONE (`MODE=1` with no hit first writes 0xFFFFFFFF to `output_addr` in WRITE2); otherwise i++ and go to BLK2.
- **WRITE2, 1 cycle:**
  - Hit: write H0' to `output_addr`+1, then DONE.
  - No hit: write 0xFFFFFFFF to `output_addr`, `found`=0, then DONE.
- **Address arithmetic:** 16-bit, wraps mod 2^16.
- **`mem_we`:** high only in WRITE/WRITE2 write cycles.
- **Reset mid-run:** immediate return to reset values. Partial outputs already in SRAM are left as-is; no further writes.

## Timing
- Edge 0 accepts `start`.
- `MODE=0`: `done` rises after edge 85+131·`NUM_NONCES` (2181 for 16).
- `MODE=1` hit at index i: `done` rises after edge 85+131·(i+1)+1.
- `MODE=1` no hit: `done` rises after edge 86+131·`NUM_NONCES`.
- Per-nonce throughput: 131 cycles. Header is fetched once per run.

## Test plan
- **MODE=0 golden run:** seed 0x01234567, each header word rotl1 of the previous, `message_addr`=0, `output_addr`=1000, `nonce_base`=0, N=16 → mem[1000..1015] equals the golden double-SHA H0 for nonces 0..15; `done` after edge 2181; all other SRAM untouched.
- **MODE=1, `target`=0xFFFFFFFF, `nonce_base`=0x100** → `found`=1, `found_nonce`=0x100, mem[1000]=0x100, mem[1001]=golden H0(0x100); `done` after edge 217.
- **MODE=1, `target`=0** → `found`=0, mem[1000]=0xFFFFFFFF; `done` after edge 86+131·N.
- **Nonce wrap:** `nonce_base`=0xFFFFFFFF, N=2, MODE=0 → results for nonces 0xFFFFFFFF then 0x00000000, matching golden.
- **Reset and restart:** assert `reset_n`=0 mid-BLK2 of nonce 3 → all outputs 0 the same cycle; after release, a fresh start gives the full correct golden result.
- **Start handling:** `start` held 2 cycles, and pulsed again during BLK1 → exactly one run, identical results and cycle count.
